screen_buffer_arbiter: RTL

- Controller that shares the single-port screen frame-buffer RAM between two requesters.
- The display scan-out side prefetches one line at a time into its line buffer and has priority.
- The host/network client side writes pixel words into the RAM.
- The block sequences line bursts, gates host writes with a valid/ready handshake, and drives the RAM port directly.

---
 rtl/screen_buffer_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/screen_buffer_arbiter.sv
// Screen frame-buffer arbiter: shares one single-port RAM between the display
// scan-out line prefetcher (priority) and host pixel writes.
`timescale 1ns/1ps

module screen_buffer_arbiter #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int LINE_WORDS = 80
) (
   input  logic              clk,
   input  logic              rst_n,
   // scan-out line fetch
   input  logic              line_req,
   input  logic [ADDR_W-1:0] line_base,
   output logic [DATA_W-1:0] line_data,
   output logic              line_valid,
   output logic              line_done,
   output logic              line_busy,
   output logic              line_overrun,
   // host write port
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   // single-port RAM
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN
   } state_e;

   // Counter value at which the final read of a line is issued.
   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(LINE_WORDS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              rd_pend_q, rd_pend_d;
   logic              overrun_q, overrun_d;

   // Next-state logic and RAM port / handshake outputs.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      wr_ready  = 1'b0;
      line_busy = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;

      unique case (state_q)
         S_IDLE: begin
            // A line request wins a same-cycle tie with a host write.
            wr_ready = !line_req;
            if (wr_valid && !line_req) begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = wr_addr;
               ram_wdata = wr_data;
            end
            if (line_req) begin
               base_d  = line_base;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            // Address arithmetic wraps naturally at 2^ADDR_W.
            line_busy = 1'b1;
            ram_en    = 1'b1;
            ram_addr  = base_q + cnt_q;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = S_DRAIN;
            end
         end

         S_DRAIN: begin
            // Bubble cycle while the final read word returns.
            line_busy = 1'b1;
            state_d   = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read-return tracking and dropped-request flag, one cycle behind the RAM.
   always_comb begin
      rd_pend_d = ram_en && !ram_we;
      overrun_d = line_req && (state_q != S_IDLE);
   end

   // State registers; reset aborts any burst in flight.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         base_q    <= '0;
         rd_pend_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         base_q    <= base_d;
         rd_pend_q <= rd_pend_d;
         overrun_q <= overrun_d;
      end
   end

   // Line-side outputs: the RAM data is forwarded untouched.
   always_comb begin
      line_data    = ram_rdata;
      line_valid   = rd_pend_q;
      line_done    = rd_pend_q && (state_q == S_DRAIN);
      line_overrun = overrun_q;
   end

endmodule
